mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the multicycle core's unified instruction/data memory port.
//   Accepts one word request at a time (fetch, load or store) and answers after a fixed, programmable wait latency.
//   Flags misaligned and out-of-range addresses.
//   Keeps saturating read/write access counters for performance checks.
//   Sits between the core's Addr/MWE/MWD/MRD path and a DEPTH-word storage array.
// PARAMETERS
//   AWL    6         word-address width; storage index = Addr[AWL+1:2]
//   DWL    32        data and byte-address width
//   DEPTH  2**AWL    number of DWL-bit words in the storage array
//   LAT    2         wait cycles between request accept and Ack (0..15)
//   CW     16        width of each access counter
// PORTS
//   CLK     in   1     clock; all state changes on its rising edge
//   RST     in   1     synchronous, active-high reset
//   Req     in   1     request; level, held by the core until Ack
//   WE      in   1     1 = store, 0 = read (fetch/load); sampled with Req
//   Addr    in   DWL   byte address; sampled with Req
//   WData   in   DWL   store data; sampled with Req
//   Busy    out  1     1 while an access is in flight (WAIT or RESP state)
//   Ack     out  1     one-cycle completion pulse
//   Err     out  1     valid with Ack; 1 = misaligned or out-of-range access
//   RData   out  DWL   read data; valid with Ack on a good read, held until the next read Ack
//   RdCnt   out  CW    completed good reads; saturates at all-ones
//   WrCnt   out  CW    completed good writes; saturates at all-ones
// BEHAVIOUR
//   Reset
//     - Busy=0, Ack=0, Err=0, RData=0, RdCnt=0, WrCnt=0.
//     - State returns to IDLE and the wait counter clears.
//     - Storage contents are NOT reset.
//   FSM states: IDLE, WAIT, RESP.
//     - IDLE: Req=1 latches WE, Addr and WData.
//       LAT=0 -> next state RESP; otherwise -> WAIT with the counter loaded to LAT-1.
//     - WAIT: decrement the counter each cycle; counter==0 -> RESP.
//     - RESP: Ack=1 for exactly one cycle, then always -> IDLE.
//   Latency
//     - Request accepted at edge k; Ack is high in the cycle after edge k+LAT+1.
//     - LAT=2: Req sampled at edge 0, Ack visible after edge 3.
//   Req handling
//     - Req is sampled only in IDLE. Changes to Req, WE, Addr or WData while Busy are ignored.
//     - Req still high in the IDLE cycle after Ack starts a new access. There is no queue.
//   Error check, on the latched address
//     - Misaligned: Addr[1:0] != 0.
//     - Out of range: any bit of Addr[DWL-1:AWL+2] set.
//     - Err=1 with Ack. No storage write, RData unchanged, no counter change.
//   Good read
//     - RData <= mem[Addr[AWL+1:2]] at the edge entering RESP.
//     - RdCnt increments at that edge.
//   Good write
//     - mem[index] <= WData at the edge entering RESP; visible to any later read.
//     - WrCnt increments at that edge; RData unchanged.
//   Counters
//     - Each counter stops at 2**CW-1; no wrap-around.
//   Reset mid-access
//     - Aborts the access: no Ack, no write, no counter update.
//     - RST has priority over every other event in the same cycle.
//   Ack, Busy and Err are registered outputs; no combinational path from inputs to outputs.
// TESTING
//   1. Write then read, LAT=2
//      - Store Addr=0x8, WData=0xDEADBEEF -> Ack at cycle +3, WrCnt=1.
//      - Then read Addr=0x8 -> RData=0xDEADBEEF, Err=0, RdCnt=1.
//   2. Misaligned access
//      - Store Addr=0x6 -> Ack with Err=1, WrCnt stays 0.
//      - Read of word 1 (Addr=0x4) returns its prior value.
//   3. Out of range, AWL=6
//      - Read Addr=0x100 -> Ack with Err=1, RData unchanged, RdCnt unchanged.
//   4. LAT=0, back-to-back
//      - Req held high across two reads of 0x0 and 0x4.
//      - Ack pulses 2 cycles apart; Busy drops for exactly 1 IDLE cycle between them.
//   5. Reset mid-access
//      - Store to 0xC, RST asserted during WAIT -> no Ack, WrCnt=0.
//      - A later read of 0xC returns the pre-store value.
//   6. Saturation, CW=4
//      - 17 good reads -> RdCnt stops at 15.
//      - Change Addr/WE while Busy -> the latched access completes unaffected.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory responder with programmable wait latency, address error flagging
// and saturating read/write access counters.
module mem_responder #(
  parameter int AWL   = 6,
  parameter int DWL   = 32,
  parameter int DEPTH = 2**AWL,
  parameter int LAT   = 2,
  parameter int CW    = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Req,
  input  logic           WE,
  input  logic [DWL-1:0] Addr,
  input  logic [DWL-1:0] WData,
  output logic           Busy,
  output logic           Ack,
  output logic           Err,
  output logic [DWL-1:0] RData,
  output logic [CW-1:0]  RdCnt,
  output logic [CW-1:0]  WrCnt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] LAT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [DWL-1:0]   addr_q, addr_d;
  logic [DWL-1:0]   wdata_q, wdata_d;
  logic [DWL-1:0]   rdata_q, rdata_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [DWL-1:0]   mem_q [DEPTH];
  logic             mem_we;
  logic [AWL-1:0]   acc_idx;
  logic             acc_bad;
  logic             enter_resp;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && mem_we) begin
      mem_q[acc_idx] <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (Req) begin
          we_d    = WE;
          addr_d  = Addr;
          wdata_d = WData;
          if (LAT == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // addr_d is the address of the access in flight, including the one being latched with LAT=0
  assign acc_idx    = addr_d[AWL+1:2];
  assign acc_bad    = (|addr_d[1:0]) || (|addr_d[DWL-1:AWL+2]);
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    busy_d   = (state_d != IDLE);
    ack_d    = (state_q == RESP);
    err_d    = ack_d && acc_bad;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;
    if (enter_resp && !acc_bad) begin
      if (we_d) begin
        mem_we   = 1'b1;
        wr_cnt_d = (&wr_cnt_q) ? wr_cnt_q : wr_cnt_q + 1'b1;
      end else begin
        rdata_d  = mem_q[acc_idx];
        rd_cnt_d = (&rd_cnt_q) ? rd_cnt_q : rd_cnt_q + 1'b1;
      end
    end
  end

  assign Busy  = busy_q;
  assign Ack   = ack_q;
  assign Err   = err_q;
  assign RData = rdata_q;
  assign RdCnt = rd_cnt_q;
  assign WrCnt = wr_cnt_q;

endmodule
